collector_arbiter: RTL

Round-robin arbiter that shares one packet collector (sink) among `numReq` upstream local-port requesters. It sits between the router local outputs and a single collector instance, speaking the collector's Req/Gnt handshake on both sides. Each transfer has three parts: it latches one winner's packet, presents it downstream until granted, then returns a one-cycle grant to the winner. It also exports the current winner and a running delivered-packet count for the simulation log.

---
 rtl/collector_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/collector_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : collector_arbiter
// Purpose  : Round-robin arbiter sharing one packet collector among numReq
//            local-port requesters. Each transfer latches one winner's packet,
//            presents it downstream until the collector grants it, then
//            returns a single-cycle grant pulse to the winner.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1                  rising-edge clock
//   reset      in   1                  asynchronous active-low reset
//   ReqIn      in   numReq             per-requester request
//   PacketIn   in   numReq*dataWidth   flattened packets, slice i = requester i
//   GntOut     out  numReq             one-cycle grant to the served requester
//   FullOut    out  numReq             registered DnStrFull, replicated
//   PacketOut  out  dataWidth          latched packet toward the collector
//   ReqDnStr   out  1                  request to the collector
//   GntDnStr   in   1                  grant from the collector
//   DnStrFull  in   1                  collector full
//   CurSender  out  idWidth            index of the last/current winner
//   PktCount   out  16                 delivered-packet count, wraps
// ============================================================================
module collector_arbiter #(
    parameter int dataWidth = 32,
    parameter int numReq    = 4,
    parameter int idWidth   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [numReq-1:0]             ReqIn,
    input  logic [numReq*dataWidth-1:0]   PacketIn,
    output logic [numReq-1:0]             GntOut,
    output logic [numReq-1:0]             FullOut,
    output logic [dataWidth-1:0]          PacketOut,
    output logic                          ReqDnStr,
    input  logic                          GntDnStr,
    input  logic                          DnStrFull,
    output logic [idWidth-1:0]            CurSender,
    output logic [15:0]                   PktCount
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                 state;
    logic [idWidth-1:0]     last_winner;

    logic [idWidth-1:0]     winner;
    logic                   winner_valid;
    logic [numReq-1:0]      req_shifted;
    int                     idx;

    // Scan offsets from the far end down to last_winner+1 so that the nearest
    // requesting index (lowest offset) is the final assignment and wins.
    always_comb begin
        winner       = '0;
        winner_valid = 1'b0;
        req_shifted  = '0;
        idx          = 0;
        for (int k = numReq; k >= 1; k--) begin
            idx         = (int'(last_winner) + k) % numReq;
            req_shifted = ReqIn >> idx;
            if (req_shifted[0]) begin
                winner       = idWidth'(idx);
                winner_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            last_winner <= idWidth'(numReq - 1);
            GntOut      <= '0;
            FullOut     <= '0;
            PacketOut   <= '0;
            ReqDnStr    <= 1'b0;
            CurSender   <= '0;
            PktCount    <= '0;
        end else begin
            FullOut <= {numReq{DnStrFull}};
            case (state)
                ST_IDLE: begin
                    GntOut <= '0;
                    if (!DnStrFull && winner_valid) begin
                        PacketOut <= PacketIn[winner*dataWidth +: dataWidth];
                        CurSender <= winner;
                        ReqDnStr  <= 1'b1;
                        state     <= ST_SEND;
                    end else begin
                        ReqDnStr  <= 1'b0;
                    end
                end
                ST_SEND: begin
                    // A rising DnStrFull here is ignored: the packet is
                    // already committed to this collector handshake.
                    if (GntDnStr) begin
                        ReqDnStr    <= 1'b0;
                        GntOut      <= {{(numReq-1){1'b0}}, 1'b1} << CurSender;
                        last_winner <= CurSender;
                        PktCount    <= PktCount + 16'd1;
                        state       <= ST_RELEASE;
                    end else begin
                        ReqDnStr    <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    // Wait for the collector to drop its grant so the next
                    // request cannot be captured by the same receive cycle.
                    GntOut <= '0;
                    if (!GntDnStr) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    GntOut   <= '0;
                    ReqDnStr <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
